// File: rtl/wrapper_packet_deconstruct_fifo.sv
// Read-side packet deconstructor with a DEPTH-entry packet FIFO. Software drains
// the head packet 32 bits at a time through the data region and controls/monitors
// the FIFO through a single status word.
module wrapper_packet_deconstruct_fifo #(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 256,
  parameter int DEPTH       = 2,
  parameter int POP_MODE    = 0,
  localparam int PSW        = ADDRWIDTH - $clog2(PACKETWIDTH / 8),
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic                   read_en,
  input  logic                   write_en,
  input  logic [3:0]             byte_strobe,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   wready,
  output logic                   rready,
  input  logic [PACKETWIDTH-1:0] packet_data,
  input  logic                   packet_data_last,
  input  logic [PSW-1:0]         packet_data_remain,
  input  logic                   packet_data_valid,
  output logic                   packet_data_ready,
  output logic [PSW:0]           block_packet_count,
  output logic [LW-1:0]          fifo_level,
  output logic                   deconstructor_ready
);

  localparam int NWORDS = PACKETWIDTH / 32;
  localparam int WSW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PACKETWIDTH-1:0] mem_data   [DEPTH];
  logic [PSW-1:0]         mem_remain [DEPTH];
  logic                   mem_last   [DEPTH];
  logic                   mem_first  [DEPTH];

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [LW-1:0]     level;
  logic [NWORDS-1:0] flags;
  logic              start;
  logic              underflow;
  logic [PSW:0]      bpc;

  logic              status_sel, empty, full, flush, clr_uf;
  logic              push, pop, data_rd, rd_ok;
  logic [WSW-1:0]    word_sel;
  logic [NWORDS-1:0] cur_bit;
  logic              head_last;
  logic [31:0]       status_word;
  logic              unused_bits;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + PW'(1);
  endfunction

  assign unused_bits = ^{byte_strobe[3:1], wdata[31:2], addr[1:0], addr[ADDRWIDTH-2:WSW+2]};

  // Decode strobes, FIFO state flags and release condition
  always_comb begin
    status_sel = addr[ADDRWIDTH-1];
    word_sel   = (NWORDS == 1) ? '0 : addr[WSW+1:2];
    cur_bit    = NWORDS'(1) << word_sel;
    empty      = (level == '0);
    full       = (level == LW'(DEPTH));
    flush      = write_en && status_sel && byte_strobe[0] && wdata[0];
    clr_uf     = write_en && status_sel && byte_strobe[0] && wdata[1];
    push       = packet_data_valid && !full && !flush;
    data_rd    = read_en && !status_sel;
    rd_ok      = data_rd && !empty;
    pop        = 1'b0;
    if (POP_MODE == 0) pop = rd_ok && (&(flags | cur_bit));
    else               pop = rd_ok && (word_sel == WSW'(NWORDS - 1));
    head_last  = !empty && mem_last[rd_ptr];
    status_word = {16'(bpc), 4'b0000, underflow, head_last, full, empty, 8'(level)};
  end

  // Register-side read data and handshake outputs
  always_comb begin
    rdata = '0;
    if (read_en) begin
      if (status_sel)  rdata = status_word;
      else if (!empty) rdata = mem_data[rd_ptr][word_sel*32 +: 32];
    end
    rready              = status_sel ? 1'b1 : !empty;
    wready              = 1'b1;
    packet_data_ready   = !full && !flush;
    deconstructor_ready = !empty;
    fifo_level          = level;
    block_packet_count  = bpc;
  end

  // Packet storage; contents are only observed through valid head entries
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_data[wr_ptr]   <= packet_data;
      mem_remain[wr_ptr] <= packet_data_remain;
      mem_last[wr_ptr]   <= packet_data_last;
      mem_first[wr_ptr]  <= start;
    end
  end

  // Pointers, level, read flags, block tracking and sticky underflow
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      flags     <= '0;
      start     <= 1'b1;
      underflow <= 1'b0;
      bpc       <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
        flags  <= '0;
        start  <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr <= ptr_next(wr_ptr);
          start  <= packet_data_last;
        end
        if (pop) begin
          rd_ptr <= ptr_next(rd_ptr);
          flags  <= '0;
        end else if (rd_ok) begin
          flags <= flags | cur_bit;
        end
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      // an underflow in the same cycle as a clear is kept so the event is not lost
      if (data_rd && empty) underflow <= 1'b1;
      else if (clr_uf)      underflow <= 1'b0;
      if (!empty && mem_first[rd_ptr])
        bpc <= {1'b0, mem_remain[rd_ptr]} + (PSW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_wrapper_packet_deconstruct_fifo.sv
// Directed bench: one instance in release-on-all-words mode, one in
// release-on-last-word mode, sharing stimulus gated by dsel.
module tb_wrapper_packet_deconstruct_fifo;

  localparam int AW  = 11;
  localparam int PWD = 256;
  localparam int PSW = 6;
  localparam int LW  = 2;
  localparam logic [AW-1:0] STAT = 11'h400;

  logic           hclk = 1'b0;
  logic           hresetn;
  logic [AW-1:0]  addr;
  logic           read_en, write_en, packet_data_valid, packet_data_last;
  logic [3:0]     byte_strobe;
  logic [31:0]    wdata;
  logic [PWD-1:0] packet_data;
  logic [PSW-1:0] packet_data_remain;
  logic           dsel;

  logic [31:0]    rdata0, rdata1;
  logic           wready0, wready1, rready0, rready1;
  logic           pready0, pready1, dr0, dr1;
  logic [PSW:0]   bpc0, bpc1;
  logic [LW-1:0]  level0, level1;

  logic [31:0]    rdata_m;
  logic           rready_m, pready_m, dr_m;
  logic [PSW:0]   bpc_m;
  logic [LW-1:0]  level_m;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  assign rdata_m  = dsel ? rdata1  : rdata0;
  assign rready_m = dsel ? rready1 : rready0;
  assign pready_m = dsel ? pready1 : pready0;
  assign dr_m     = dsel ? dr1     : dr0;
  assign bpc_m    = dsel ? bpc1    : bpc0;
  assign level_m  = dsel ? level1  : level0;

  wrapper_packet_deconstruct_fifo #(
    .ADDRWIDTH(AW), .PACKETWIDTH(PWD), .DEPTH(2), .POP_MODE(0)
  ) dut0 (
    .hclk(hclk), .hresetn(hresetn), .addr(addr),
    .read_en(read_en & ~dsel), .write_en(write_en & ~dsel),
    .byte_strobe(byte_strobe), .wdata(wdata), .rdata(rdata0),
    .wready(wready0), .rready(rready0),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_remain(packet_data_remain),
    .packet_data_valid(packet_data_valid & ~dsel), .packet_data_ready(pready0),
    .block_packet_count(bpc0), .fifo_level(level0), .deconstructor_ready(dr0)
  );

  wrapper_packet_deconstruct_fifo #(
    .ADDRWIDTH(AW), .PACKETWIDTH(PWD), .DEPTH(2), .POP_MODE(1)
  ) dut1 (
    .hclk(hclk), .hresetn(hresetn), .addr(addr),
    .read_en(read_en & dsel), .write_en(write_en & dsel),
    .byte_strobe(byte_strobe), .wdata(wdata), .rdata(rdata1),
    .wready(wready1), .rready(rready1),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_remain(packet_data_remain),
    .packet_data_valid(packet_data_valid & dsel), .packet_data_ready(pready1),
    .block_packet_count(bpc1), .fifo_level(level1), .deconstructor_ready(dr1)
  );

  function automatic logic [PWD-1:0] mkpkt(input logic [31:0] base);
    logic [PWD-1:0] p;
    for (int w = 0; w < 8; w++) p[w*32 +: 32] = base + 32'(w);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] base, input logic [PSW-1:0] rem, input logic lst);
    packet_data        = mkpkt(base);
    packet_data_remain = rem;
    packet_data_last   = lst;
    packet_data_valid  = 1'b1;
    tick();
    packet_data_valid  = 1'b0;
  endtask

  task automatic rd_word(input string tag, input int w, input logic [31:0] base);
    addr    = AW'(w * 4);
    read_en = 1'b1;
    #1 chk(tag, rdata_m, base + 32'(w));
    tick();
    read_en = 1'b0;
  endtask

  task automatic read_packet(input string tag, input logic [31:0] base);
    for (int w = 0; w < 8; w++) rd_word(tag, w, base);
  endtask

  initial begin
    hresetn = 1'b0; dsel = 1'b0; addr = '0; read_en = 1'b0; write_en = 1'b0;
    byte_strobe = '0; wdata = '0; packet_data = '0; packet_data_last = 1'b0;
    packet_data_remain = '0; packet_data_valid = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_pready", 32'(pready0), 32'd1);
    chk("rst_dr",     32'(dr0),     32'd0);
    chk("rst_rready", 32'(rready0), 32'd0);
    chk("rst_wready", 32'(wready0), 32'd1);
    chk("rst_rdata",  rdata0,       32'd0);
    chk("rst_level",  32'(level0),  32'd0);
    chk("rst_bpc",    32'(bpc0),    32'd0);
    chk("rst_level1", 32'(level1),  32'd0);
    hresetn = 1'b1;
    tick();

    // release on last word, underflow, underflow clear
    dsel = 1'b1;
    push_beat(32'h1A00_0000, 6'd2, 1'b0);
    chk("m1_level_push", 32'(level_m), 32'd1);
    rd_word("m1_word7", 7, 32'h1A00_0000);
    chk("m1_level_pop", 32'(level_m), 32'd0);
    chk("m1_dr_pop",    32'(dr_m),    32'd0);
    addr = '0; read_en = 1'b1;
    #1 chk("m1_empty_rdata", rdata_m, 32'd0);
    chk("m1_empty_rready", 32'(rready_m), 32'd0);
    tick();
    addr = STAT;
    #1 chk("m1_status_uf", rdata_m, 32'h0003_0900);
    read_en = 1'b0; write_en = 1'b1; byte_strobe = 4'h1; wdata = 32'h2;
    tick();
    write_en = 1'b0; byte_strobe = '0; wdata = '0; read_en = 1'b1;
    #1 chk("m1_status_clr", rdata_m, 32'h0003_0100);
    tick();
    read_en = 1'b0; dsel = 1'b0;

    // fill to full, stall third beat, drain head in reverse
    push_beat(32'hA000_0000, 6'd2, 1'b0);
    push_beat(32'hB000_0000, 6'd1, 1'b0);
    packet_data = mkpkt(32'hC000_0000); packet_data_remain = '0;
    packet_data_last = 1'b1; packet_data_valid = 1'b1;
    #1 chk("full_pready", 32'(pready_m), 32'd0);
    chk("full_level", 32'(level_m), 32'd2);
    addr = STAT; read_en = 1'b1;
    #1 chk("full_status", rdata_m, 32'h0003_0202);
    chk("stat_rready", 32'(rready_m), 32'd1);
    tick();
    for (int w = 7; w >= 0; w--) begin
      addr = AW'(w * 4);
      #1 chk("rev_rdata", rdata_m, 32'hA000_0000 + 32'(w));
      chk("rev_pready", 32'(pready_m), 32'd0);
      tick();
    end
    read_en = 1'b0;
    #1 chk("popA_level",  32'(level_m), 32'd1);
    chk("popA_pready", 32'(pready_m), 32'd1);
    chk("popA_bpc",    32'(bpc_m),    32'd3);
    tick();
    packet_data_valid = 1'b0;
    chk("C_level", 32'(level_m), 32'd2);
    chk("C_bpc",   32'(bpc_m),   32'd3);
    read_packet("B_data", 32'hB000_0000);
    read_packet("C_data", 32'hC000_0000);
    chk("BC_level", 32'(level_m), 32'd0);
    chk("BC_bpc",   32'(bpc_m),   32'd3);

    // push in the same cycle as the completing read
    push_beat(32'h5800_0000, 6'd0, 1'b1);
    for (int w = 0; w < 7; w++) rd_word("X_data", w, 32'h5800_0000);
    addr = AW'(28); read_en = 1'b1;
    packet_data = mkpkt(32'h5900_0000); packet_data_remain = '0;
    packet_data_last = 1'b1; packet_data_valid = 1'b1;
    #1 chk("X_word7", rdata_m, 32'h5800_0007);
    chk("XY_pready", 32'(pready_m), 32'd1);
    tick();
    read_en = 1'b0; packet_data_valid = 1'b0;
    #1 chk("XY_level", 32'(level_m), 32'd1);
    chk("XY_dr", 32'(dr_m), 32'd1);
    read_packet("Y_data", 32'h5900_0000);
    chk("Y_level", 32'(level_m), 32'd0);

    // two blocks, count follows the head
    push_beat(32'h7000_0000, 6'd0, 1'b1);
    push_beat(32'h7100_0000, 6'd4, 1'b0);
    chk("blk_level", 32'(level_m), 32'd2);
    chk("blk_bpc1",  32'(bpc_m),   32'd1);
    read_packet("P_data", 32'h7000_0000);
    chk("blk_bpc_pop", 32'(bpc_m), 32'd1);
    tick();
    chk("blk_bpc5",  32'(bpc_m),   32'd5);
    chk("blk_level1", 32'(level_m), 32'd1);

    // flush while full with a beat offered
    push_beat(32'h7200_0000, 6'd3, 1'b0);
    chk("fl_full", 32'(level_m), 32'd2);
    addr = STAT; write_en = 1'b1; byte_strobe = 4'h1; wdata = 32'h1;
    packet_data = mkpkt(32'h7300_0000); packet_data_valid = 1'b1;
    #1 chk("fl_pready", 32'(pready_m), 32'd0);
    tick();
    write_en = 1'b0; byte_strobe = '0; wdata = '0; packet_data_valid = 1'b0;
    read_en = 1'b1;
    #1 chk("fl_status", rdata_m, 32'h0005_0100);
    chk("fl_pready_after", 32'(pready_m), 32'd1);
    chk("fl_level", 32'(level_m), 32'd0);
    chk("fl_dr", 32'(dr_m), 32'd0);
    tick();
    read_en = 1'b0;

    // async reset mid-drain discards partial read flags
    push_beat(32'h9000_0000, 6'd0, 1'b1);
    for (int w = 0; w < 4; w++) rd_word("Z_data", w, 32'h9000_0000);
    hresetn = 1'b0;
    #1 chk("mr_level", 32'(level_m), 32'd0);
    chk("mr_pready", 32'(pready_m), 32'd1);
    chk("mr_dr", 32'(dr_m), 32'd0);
    chk("mr_bpc", 32'(bpc_m), 32'd0);
    #1 hresetn = 1'b1;
    tick();
    push_beat(32'h9100_0000, 6'd0, 1'b1);
    for (int w = 4; w < 8; w++) rd_word("W_hi", w, 32'h9100_0000);
    chk("mr_flags_fresh", 32'(level_m), 32'd1);
    for (int w = 0; w < 4; w++) rd_word("W_lo", w, 32'h9100_0000);
    chk("mr_W_pop", 32'(level_m), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wrapper_packet_deconstruct_fifo.md
Name: wrapper_packet_deconstruct_fifo

Overview:
- Parametrised successor to the single-packet AHB read-side deconstructor.
- Buffers up to DEPTH accelerator output packets in a FIFO; software drains the head packet 32 bits at a time over the register interface.
- Adds a selectable release mode, a status/control word with flush and sticky underflow, and head-aligned block packet counting.
- Sits between the accelerator output valid/ready stream and the AHB register interface of the wrapper.

Parameters:
ADDRWIDTH, 11, register address width; addr[ADDRWIDTH-1] selects region (0 = data, 1 = status).
PACKETWIDTH, 256, packet width in bits; multiple of 32, NWORDS = PACKETWIDTH/32, power of 2.
DEPTH, 2, FIFO entries; power of 2, 1 to 128.
POP_MODE, 0, 0 = release head when all NWORDS words read; 1 = release head on read of word NWORDS-1.
PSW (local), ADDRWIDTH - clog2(PACKETWIDTH/8).
LW (local), clog2(DEPTH+1).

Ports:
hclk  in  1  clock, single domain
hresetn  in  1  asynchronous active-low reset
addr  in  ADDRWIDTH  register byte address
read_en  in  1  register read strobe
write_en  in  1  register write strobe
byte_strobe  in  4  write byte enables
wdata  in  32  write data
rdata  out  32  read data
wready  out  1  write ready
rready  out  1  read ready
packet_data  in  PACKETWIDTH  input packet
packet_data_last  in  1  last packet of block
packet_data_remain  in  PSW  packets remaining in block after this one
packet_data_valid  in  1  input valid
packet_data_ready  out  1  input ready
block_packet_count  out  PSW+1  packet count of the block owning the head packet
fifo_level  out  LW  occupied entries
deconstructor_ready  out  1  head packet available

Behaviour:
- Reset (async assert, sync release):
  - level 0, read pointer 0, write pointer 0, read-flag vector 0.
  - start flag 1, underflow 0, block_packet_count 0.
  - Resulting outputs: packet_data_ready 1, deconstructor_ready 0, rready 0, wready 1, rdata 0.
- Push: on packet_data_valid && packet_data_ready, store {data, last, remain, first = start flag}, then start flag <= packet_data_last. The entry becomes visible at the head the next cycle.
- packet_data_ready = (level != DEPTH) && !flush, where flush is a combinational status write with wdata[0] set.
- Data read (addr[ADDRWIDTH-1] = 0, read_en):
  - word_sel = addr[clog2(NWORDS)+1:2], wrapping within the packet.
  - rdata = head[word_sel] in the same cycle, combinationally.
  - Flag vector |= 1 << word_sel.
- Release:
  - POP_MODE 0: pop when (flags | cur) is all ones.
  - POP_MODE 1: pop when word_sel == NWORDS-1.
  - On pop: flags cleared, read pointer advances, level decrements.
- Data read while empty: rdata 0, flags unchanged, underflow <= 1 (sticky).
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pop from a full FIFO: ready rises the next cycle.
- block_packet_count: registered. Each cycle the head is valid and head.first = 1, it loads head.remain + 1, zero-extended. Otherwise it holds, including while empty.
- Status word (addr[ADDRWIDTH-1] = 1, any word address):
  - Read fields: [7:0] level (zero-extended), [8] empty, [9] full, [10] head.last (0 when empty), [11] underflow, [15:12] 0, [31:16] block_packet_count (zero-extended or truncated to 16).
  - Status reads do not touch flags.
- Status write with byte_strobe[0]:
  - wdata[0] = 1: flush. Next cycle level 0, pointers 0, flags 0, start flag 1; block_packet_count holds. No push is accepted in the flush cycle.
  - wdata[1] = 1: clear underflow.
  - Other bits are ignored.
- Data-region writes are ignored.
- rready = !empty for the data region, 1 for the status region.
- deconstructor_ready = !empty.
- fifo_level = level.
- rdata = 0 when read_en is low.
- Reset mid-packet discards all entries and partial read flags.

Test Plan:
1. DEPTH 2, POP_MODE 0: push A (remain 2, last 0), B, C (last 1) -> third beat stalls with ready 0. Read A words 7..0 in reverse -> A pops on the word-0 read. C is accepted the next cycle. block_packet_count = 3 throughout.
2. POP_MODE 1: push A, read only word 7 at addr 0x1C -> pop, level 1->0, flags 0. Read word 0 next -> rdata 0, status bit 11 = 1. Write status 0x2 -> bit 11 clears.
3. Push with read completing head in the same cycle, level 1 -> level stays 1, next head data correct, no beat lost or duplicated.
4. Two blocks: {remain 0, last 1} then {remain 4, last 0} -> block_packet_count 1 while first is head, 5 after pop.
5. Full FIFO, status write 0x1 with valid high -> no accept that cycle, next cycle status = 0x100 | (count<<16), ready 1.
6. Assert hresetn low mid-drain with flags 0x0F -> level 0, ready 1, deconstructor_ready 0, and fresh packet read flags start empty.
